systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Transmit side of the PE array interface. It buffers one SIZE x SIZE operand matrix A (data) and one matrix B (weights) received over a ready/valid load port. It then drives the array edges with diagonally skewed data and weight streams, per-lane valid bits and shift_en. The block sits between the host/load path and row 0 / column 0 of the systolic array.

Parameters:
DATA_WIDTH, 4, operand width, matching PE DATA_WIDTH.
SIZE, 2, array dimension; matrices are SIZE x SIZE.
FLUSH_CYCLES, 2*SIZE, number of drain cycles after the last operand.

Ports:
clk  in  1  clock.
rstn  in  1  reset, asynchronous, active-low.
ld_valid  in  1  load word valid.
ld_ready  out  1  feeder accepts a load word.
ld_data  in  DATA_WIDTH  load word. First SIZE*SIZE words are A, row-major; next SIZE*SIZE words are B, row-major.
stall  in  1  array back-pressure; freezes the feed/flush sequence.
row_data  out  SIZE*DATA_WIDTH  lane r = data_in for array row r (lane 0 in LSBs).
row_valid  out  SIZE  per-row in_valid.
col_weight  out  SIZE*DATA_WIDTH  lane c = weight_in for array column c.
col_valid  out  SIZE  per-column weight valid.
shift_en  out  1  drain/shift control to the PEs.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at the end of a job.

Behaviour:
- Reset (async, rstn low): state IDLE, all counters 0, buffers 0. Outputs: ld_ready=1, row_data=0, row_valid=0, col_weight=0, col_valid=0, shift_en=0, busy=0, done=0.
- States: IDLE, LOAD, FEED, FLUSH, DONE.
- IDLE: ld_ready=1. A handshake (ld_valid & ld_ready) stores word 0 into A[0][0], sets load index to 1 and moves to LOAD.
- LOAD: ld_ready=1. Each handshake writes the next buffer slot and increments the load index.
  - Index k < SIZE*SIZE goes to A[k/SIZE][k%SIZE]; otherwise to B.
  - The handshake on index 2*SIZE*SIZE-1 moves to FEED next cycle, with the feed counter t=0.
  - ld_valid low: the state holds with no change.
- FEED: ld_ready=0. Outputs are registered and update on the cycle t is entered.
  - row lane r: if 0 <= t-r < SIZE, row_data=A[r][t-r] and row_valid[r]=1; else 0 and 0.
  - col lane c: if 0 <= t-c < SIZE, col_weight=B[t-c][c] and col_valid[c]=1; else 0 and 0.
  - t runs 0..2*SIZE-2, so FEED lasts 2*SIZE-1 cycles. After the last t, go to FLUSH.
- FLUSH: all data, weight and valid outputs are 0; shift_en=1. Lasts FLUSH_CYCLES cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, shift_en=0. Next state is IDLE.
- First row_valid appears 1 cycle after the final load handshake. done appears 2*SIZE-1+FLUSH_CYCLES+1 cycles after that handshake when unstalled.
- stall high in FEED or FLUSH: counters and state hold, and outputs hold their current values (valids stay asserted). stall is ignored in IDLE, LOAD and DONE.
- stall asserted on the final cycle of FEED delays entry to FLUSH until the stall is released.
- Arithmetic: load index width is clog2(2*SIZE*SIZE)+1; t and the flush counter use clog2(2*SIZE)+1 bits. No wrap occurs within a job; counters reset on IDLE entry.
- Load handshakes are only accepted in IDLE/LOAD. ld_valid during FEED/FLUSH/DONE is ignored and not buffered.
- Reset mid-job discards all buffered operands; there is no partial resume.

Decomposition:
- Shared package systolic_pkg: DATA_WIDTH/SIZE defaults, state enum feeder_state_t {IDLE, LOAD, FEED, FLUSH, DONE}, and a skew-index helper function (in-range check for t-lane).
- One natural sub-module, skew_lane_mux. It takes a matrix buffer, lane index, t and a row/column select, and returns (value, valid). It is instantiated SIZE times for rows and SIZE times for columns.

Test Plan:
- Reset values: rstn low mid-sim -> ld_ready=1, busy=0, all row/col outputs 0, done=0 within the same cycle (async).
- Basic job, SIZE=2: load 1,2,3,4,5,6,7,8. Required FEED sequence:
  - t0: row={0,1}, row_valid=01, col={0,5}, col_valid=01.
  - t1: row={3,2}, row_valid=11, col={6,7}, col_valid=11.
  - t2: row={4,0}, row_valid=10, col={8,0}, col_valid=10.
  - Then 4 cycles shift_en=1, then done for 1 cycle, then IDLE.
- Load gaps: ld_valid toggled 1/0 across all 8 words -> identical feed output to the basic job; the state stays LOAD while ld_valid=0.
- Stall: stall=1 for 3 cycles at t1 -> outputs frozen at the t1 values for 4 cycles total, then t2; done is delayed by exactly 3 cycles.
- Ignored load: ld_valid=1 with ld_data=F throughout FEED/FLUSH -> ld_ready=0, no buffer corruption, a second job loads cleanly after done.
- Reset mid-FEED at t1 -> immediate IDLE outputs; a new 8-word load produces a correct fresh sequence.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
// Holds default dimensions, the feeder state enum and the skew range check.
package systolic_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int SIZE_DEF       = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        FLUSH,
        DONE
    } feeder_state_t;

    // Lane `lane` carries an operand at step t only while 0 <= t-lane < size.
    function automatic logic skew_in_range(input int t, input int lane, input int size);
        return ((t - lane) >= 0) && ((t - lane) < size);
    endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Selects the skewed operand for one array lane at feed step t.
// Row mode reads A[lane][t-lane]; column mode reads B[t-lane][lane].
module skew_lane_mux
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SIZE       = SIZE_DEF,
    parameter int TW         = 3
) (
    input  logic [SIZE*SIZE*DATA_WIDTH-1:0] mat_i,
    input  logic [TW-1:0]                   lane_i,
    input  logic [TW-1:0]                   t_i,
    input  logic                            col_sel_i,
    output logic [DATA_WIDTH-1:0]           val_o,
    output logic                            valid_o
);

    int d;
    int idx;

    always_comb begin
        val_o   = '0;
        valid_o = 1'b0;
        d       = int'(t_i) - int'(lane_i);
        idx     = 0;
        if (skew_in_range(int'(t_i), int'(lane_i), SIZE)) begin
            idx     = col_sel_i ? (d * SIZE + int'(lane_i))
                                : (int'(lane_i) * SIZE + d);
            valid_o = 1'b1;
            val_o   = mat_i[idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers operand matrices A and B from the load port, then drives the
// array edges with diagonally skewed streams followed by a flush drain.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int SIZE         = SIZE_DEF,
    parameter int FLUSH_CYCLES = 2 * SIZE
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [DATA_WIDTH-1:0]      ld_data,
    input  logic                       stall,
    output logic [SIZE*DATA_WIDTH-1:0] row_data,
    output logic [SIZE-1:0]            row_valid,
    output logic [SIZE*DATA_WIDTH-1:0] col_weight,
    output logic [SIZE-1:0]            col_valid,
    output logic                       shift_en,
    output logic                       busy,
    output logic                       done
);

    localparam int N   = SIZE * SIZE;
    localparam int LIW = $clog2(2 * N) + 1;
    localparam int TW  = $clog2(2 * SIZE) + 1;
    localparam int MW  = N * DATA_WIDTH;
    localparam int LW  = SIZE * DATA_WIDTH;

    feeder_state_t state_q, state_d;
    logic [LIW-1:0] ld_idx_q, ld_idx_d;
    logic [TW-1:0]  t_q, t_d;
    logic [TW-1:0]  fl_q, fl_d;
    logic [2*MW-1:0] buf_q, buf_d;

    logic [LW-1:0]   row_data_q, row_data_d;
    logic [LW-1:0]   col_weight_q, col_weight_d;
    logic [SIZE-1:0] row_valid_q, row_valid_d;
    logic [SIZE-1:0] col_valid_q, col_valid_d;
    logic            shift_en_q, shift_en_d;
    logic            done_q, done_d;

    logic [LW-1:0]   row_mux, col_mux;
    logic [SIZE-1:0] row_mux_v, col_mux_v;
    logic            ld_hs;

    assign ld_ready = (state_q == IDLE) || (state_q == LOAD);
    assign ld_hs    = ld_valid && ld_ready;
    assign busy     = (state_q != IDLE);

    // A occupies the low half of the buffer, B the high half, both row-major,
    // so the load index addresses the buffer directly.
    always_comb begin
        state_d  = state_q;
        ld_idx_d = ld_idx_q;
        t_d      = t_q;
        fl_d     = fl_q;
        buf_d    = buf_q;
        unique case (state_q)
            IDLE: begin
                ld_idx_d = '0;
                t_d      = '0;
                fl_d     = '0;
                if (ld_hs) begin
                    buf_d[0 +: DATA_WIDTH] = ld_data;
                    ld_idx_d = LIW'(1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (ld_hs) begin
                    buf_d[int'(ld_idx_q)*DATA_WIDTH +: DATA_WIDTH] = ld_data;
                    if (ld_idx_q == LIW'(2 * N - 1)) begin
                        state_d = FEED;
                        t_d     = '0;
                    end else begin
                        ld_idx_d = ld_idx_q + LIW'(1);
                    end
                end
            end
            FEED: begin
                if (!stall) begin
                    if (t_q == TW'(2 * SIZE - 2)) begin
                        state_d = FLUSH;
                        fl_d    = '0;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    if (fl_q == TW'(FLUSH_CYCLES - 1)) begin
                        state_d = DONE;
                    end else begin
                        fl_d = fl_q + TW'(1);
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                ld_idx_d = '0;
                t_d      = '0;
                fl_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar l = 0; l < SIZE; l++) begin : g_lane
        skew_lane_mux #(
            .DATA_WIDTH(DATA_WIDTH),
            .SIZE      (SIZE),
            .TW        (TW)
        ) u_row (
            .mat_i    (buf_d[MW-1:0]),
            .lane_i   (TW'(l)),
            .t_i      (t_d),
            .col_sel_i(1'b0),
            .val_o    (row_mux[l*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o  (row_mux_v[l])
        );
        skew_lane_mux #(
            .DATA_WIDTH(DATA_WIDTH),
            .SIZE      (SIZE),
            .TW        (TW)
        ) u_col (
            .mat_i    (buf_d[2*MW-1:MW]),
            .lane_i   (TW'(l)),
            .t_i      (t_d),
            .col_sel_i(1'b1),
            .val_o    (col_mux[l*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o  (col_mux_v[l])
        );
    end

    // Outputs are computed from the next state so they change on the cycle a
    // new step is entered and simply repeat while a stall holds the counters.
    always_comb begin
        row_data_d   = '0;
        row_valid_d  = '0;
        col_weight_d = '0;
        col_valid_d  = '0;
        shift_en_d   = (state_d == FLUSH);
        done_d       = (state_d == DONE);
        if (state_d == FEED) begin
            row_data_d   = row_mux;
            row_valid_d  = row_mux_v;
            col_weight_d = col_mux;
            col_valid_d  = col_mux_v;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            ld_idx_q     <= '0;
            t_q          <= '0;
            fl_q         <= '0;
            buf_q        <= '0;
            row_data_q   <= '0;
            row_valid_q  <= '0;
            col_weight_q <= '0;
            col_valid_q  <= '0;
            shift_en_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_idx_q     <= ld_idx_d;
            t_q          <= t_d;
            fl_q         <= fl_d;
            buf_q        <= buf_d;
            row_data_q   <= row_data_d;
            row_valid_q  <= row_valid_d;
            col_weight_q <= col_weight_d;
            col_valid_q  <= col_valid_d;
            shift_en_q   <= shift_en_d;
            done_q       <= done_d;
        end
    end

    assign row_data   = row_data_q;
    assign row_valid  = row_valid_q;
    assign col_weight = col_weight_q;
    assign col_valid  = col_valid_q;
    assign shift_en   = shift_en_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a job-phase reference model
// checked every cycle, plus literal feed tables for the standard jobs.
module tb_systolic_feeder;

    localparam int DW    = 4;
    localparam int S     = 2;
    localparam int N     = S * S;
    localparam int F     = 2 * S;
    localparam int DONEP = 2 * S + F;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          stall;
    logic [S*DW-1:0] row_data;
    logic [S-1:0]    row_valid;
    logic [S*DW-1:0] col_weight;
    logic [S-1:0]    col_valid;
    logic          shift_en;
    logic          busy;
    logic          done;

    systolic_feeder #(
        .DATA_WIDTH  (DW),
        .SIZE        (S),
        .FLUSH_CYCLES(F)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .stall     (stall),
        .row_data  (row_data),
        .row_valid (row_valid),
        .col_weight(col_weight),
        .col_valid (col_valid),
        .shift_en  (shift_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: ph counts job progress after the final load word
    // (1..2S-1 feed steps, then F flush cycles, then one done cycle).
    int ph;
    int nw;
    logic [DW-1:0] mem [2*N];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph <= 0;
            nw <= 0;
        end else if (ph == 0) begin
            if (ld_valid) begin
                mem[nw] <= ld_data;
                if (nw == 2 * N - 1) begin
                    nw <= 0;
                    ph <= 1;
                end else begin
                    nw <= nw + 1;
                end
            end
        end else if (ph == DONEP) begin
            ph <= 0;
        end else if (!stall) begin
            ph <= ph + 1;
        end
    end

    always @(negedge clk) begin
        logic [S*DW-1:0] erd, ecw;
        logic [S-1:0] erv, ecv;
        int t, d;
        erd = '0; ecw = '0; erv = '0; ecv = '0;
        if (chk_on) begin
            if (ph >= 1 && ph <= 2 * S - 1) begin
                t = ph - 1;
                for (int l = 0; l < S; l++) begin
                    d = t - l;
                    if (d >= 0 && d < S) begin
                        erd[l*DW +: DW] = mem[l*S + d];
                        erv[l] = 1'b1;
                        ecw[l*DW +: DW] = mem[N + d*S + l];
                        ecv[l] = 1'b1;
                    end
                end
            end
            chk("row_data", 32'(row_data), 32'(erd));
            chk("row_valid", 32'(row_valid), 32'(erv));
            chk("col_weight", 32'(col_weight), 32'(ecw));
            chk("col_valid", 32'(col_valid), 32'(ecv));
            chk("shift_en", 32'(shift_en), 32'(ph >= 2 * S && ph <= DONEP - 1));
            chk("done", 32'(done), 32'(ph == DONEP));
            chk("ld_ready", 32'(ld_ready), 32'(ph == 0));
            chk("busy", 32'(busy), 32'(ph != 0 || nw != 0));
        end
    end

    // {row_data, row_valid, col_weight, col_valid, shift_en, done}
    logic [21:0] hist [41];
    logic [21:0] basic [1:8];
    logic [21:0] alt   [1:3];

    task automatic load_words(input logic [DW-1:0] w [8], input bit gaps);
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1;
            ld_data  = w[i];
            @(posedge clk); #1;
            if (gaps && i != 7) begin
                ld_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            hist[i] = {row_data, row_valid, col_weight, col_valid, shift_en, done};
            if (done) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_now(input string tag);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_outs"}, 32'({row_data, row_valid, col_weight, col_valid}), 32'd0);
        chk({tag, "_shift_done"}, 32'({shift_en, done}), 32'd0);
    endtask

    logic [DW-1:0] w1 [8];
    logic [DW-1:0] w2 [8];
    int cyc;

    initial begin
        w1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        w2 = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        basic[1] = {8'h01, 2'b01, 8'h05, 2'b01, 1'b0, 1'b0};
        basic[2] = {8'h32, 2'b11, 8'h67, 2'b11, 1'b0, 1'b0};
        basic[3] = {8'h40, 2'b10, 8'h80, 2'b10, 1'b0, 1'b0};
        for (int i = 4; i <= 7; i++) basic[i] = {20'h0, 1'b1, 1'b0};
        basic[8] = {20'h0, 1'b0, 1'b1};
        alt[1] = {8'h08, 2'b01, 8'h04, 2'b01, 1'b0, 1'b0};
        alt[2] = {8'h67, 2'b11, 8'h32, 2'b11, 1'b0, 1'b0};
        alt[3] = {8'h50, 2'b10, 8'h10, 2'b10, 1'b0, 1'b0};

        rstn = 1'b0; ld_valid = 1'b0; ld_data = '0; stall = 1'b0;
        #12;
        idle_now("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        chk_on = 1'b1;

        // basic job
        load_words(w1, 1'b0);
        wait_done(cyc);
        chk("basic_latency", 32'(cyc), 32'd8);
        for (int i = 1; i <= 8; i++) chk("basic_seq", 32'(hist[i]), 32'(basic[i]));
        @(posedge clk); #1;

        // load with gaps
        load_words(w1, 1'b1);
        wait_done(cyc);
        chk("gap_latency", 32'(cyc), 32'd8);
        for (int i = 1; i <= 8; i++) chk("gap_seq", 32'(hist[i]), 32'(basic[i]));
        @(posedge clk); #1;

        // three-cycle stall at t1
        load_words(w1, 1'b0);
        fork
            begin
                @(posedge clk); #1;
                stall = 1'b1;
                repeat (3) @(posedge clk);
                #1 stall = 1'b0;
            end
        join_none
        wait_done(cyc);
        chk("stall_latency", 32'(cyc), 32'd11);
        for (int i = 2; i <= 5; i++) chk("stall_hold", 32'(hist[i]), 32'(basic[2]));
        chk("stall_t2", 32'(hist[6]), 32'(basic[3]));
        @(posedge clk); #1;

        // load attempts during feed/flush are ignored
        load_words(w2, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 4'hF;
        wait_done(cyc);
        ld_valid = 1'b0;
        chk("ignore_latency", 32'(cyc), 32'd8);
        for (int i = 1; i <= 3; i++) chk("ignore_seq", 32'(hist[i]), 32'(alt[i]));
        @(posedge clk); #1;
        load_words(w1, 1'b0);
        wait_done(cyc);
        chk("second_latency", 32'(cyc), 32'd8);
        for (int i = 1; i <= 8; i++) chk("second_seq", 32'(hist[i]), 32'(basic[i]));
        @(posedge clk); #1;

        // reset in the middle of feed
        load_words(w1, 1'b0);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        idle_now("midreset");
        @(posedge clk); #1;
        rstn = 1'b1;
        load_words(w2, 1'b0);
        wait_done(cyc);
        chk("fresh_latency", 32'(cyc), 32'd8);
        for (int i = 1; i <= 3; i++) chk("fresh_seq", 32'(hist[i]), 32'(alt[i]));
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
